// File: rtl/ftoi_pipe_if.sv
// Operand/result handshake bundle for the float-to-int converter.
interface ftoi_pipe_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] x;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] y;
    logic        ovf;

    // Producer of operands / consumer of results
    modport master (
        output in_valid, x, out_ready,
        input  in_ready, out_valid, y, ovf
    );

    // The converter itself
    modport slave (
        input  in_valid, x, out_ready,
        output in_ready, out_valid, y, ovf
    );
endinterface

// File: rtl/ftoi_pipe.sv
// Two-stage IEEE-754 single float to signed 32-bit integer converter.
// S1 decodes and aligns the mantissa, S2 rounds half away from zero,
// negates and saturates. Valid/ready flow control on both sides.
module ftoi_pipe (
    input  logic        clk,
    input  logic        rst,
    ftoi_pipe_if.slave  bus
);
    localparam int unsigned DW   = 32;
    localparam int unsigned EW   = 8;
    localparam int unsigned FW   = 23;
    localparam int unsigned MW   = FW + 1;
    localparam int unsigned MAGW = 31;

    localparam logic [EW-1:0] E_INF      = 8'd255;
    localparam logic [EW-1:0] E_TOO_BIG  = 8'd158;
    localparam logic [EW-1:0] E_SHL_MIN  = 8'd151;
    localparam logic [EW-1:0] E_NO_SHIFT = 8'd150;
    localparam logic [EW-1:0] E_ONE      = 8'd127;
    localparam logic [EW-1:0] E_HALF     = 8'd126;
    localparam logic [DW-1:0] X_INT_MIN  = 32'hCF00_0000;
    localparam logic [DW-1:0] Y_POS_SAT  = 32'h7FFF_FFFF;
    localparam logic [DW-1:0] Y_NEG_SAT  = 32'h8000_0000;

    logic [EW-1:0]   exp_in;
    logic [FW-1:0]   frac_in;
    logic [MW-1:0]   mant;
    logic [DW-1:0]   align;
    logic [MAGW-1:0] dec_mag;
    logic            dec_rnd;
    logic            dec_sat;
    logic            dec_min;
    logic            dec_nan;

    logic            s1_valid;
    logic            s1_sign;
    logic [MAGW-1:0] s1_mag;
    logic            s1_rnd;
    logic            s1_sat;
    logic            s1_min;
    logic            s1_nan;

    logic            s1_load;
    logic            s2_load;
    logic [DW-1:0]   mag_r;
    logic [DW-1:0]   y_next;
    logic            ovf_next;

    assign exp_in  = bus.x[30:23];
    assign frac_in = bus.x[22:0];
    assign mant    = {1'b1, frac_in};

    // Stage advance: S2 frees when empty or drained, S1 when empty or moving on
    assign s2_load     = !bus.out_valid || bus.out_ready;
    assign s1_load     = !s1_valid || s2_load;
    assign bus.in_ready = s1_load;

    // S1 decode: classify exponent and align mantissa into integer + round bit
    always_comb begin
        align   = '0;
        dec_mag = '0;
        dec_rnd = 1'b0;
        dec_sat = 1'b0;
        dec_min = 1'b0;
        dec_nan = 1'b0;
        if (exp_in == E_INF) begin
            dec_sat = 1'b1;
            dec_nan = |frac_in;
        end else if (exp_in >= E_TOO_BIG) begin
            if (bus.x == X_INT_MIN) dec_min = 1'b1;
            else                    dec_sat = 1'b1;
        end else if (exp_in >= E_SHL_MIN) begin
            dec_mag = MAGW'({7'b0, mant} << 3'(exp_in - E_NO_SHIFT));
        end else if (exp_in >= E_ONE) begin
            // Extra zero LSB below the mantissa catches the first dropped bit
            align   = {7'b0, mant, 1'b0} >> 5'(E_NO_SHIFT - exp_in);
            dec_mag = align[DW-1:1];
            dec_rnd = align[0];
        end else if (exp_in == E_HALF) begin
            dec_rnd = 1'b1;
        end
    end

    // S2 compute: round, apply sign, substitute saturation values
    always_comb begin
        mag_r    = DW'(s1_mag) + DW'(s1_rnd);
        y_next   = s1_sign ? (DW'(0) - mag_r) : mag_r;
        ovf_next = 1'b0;
        if (s1_min) begin
            y_next = Y_NEG_SAT;
        end else if (s1_sat) begin
            y_next   = (s1_sign && !s1_nan) ? Y_NEG_SAT : Y_POS_SAT;
            ovf_next = 1'b1;
        end
    end

    // Pipeline registers; stalled stages hold data and valid
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid      <= 1'b0;
            s1_sign       <= 1'b0;
            s1_mag        <= '0;
            s1_rnd        <= 1'b0;
            s1_sat        <= 1'b0;
            s1_min        <= 1'b0;
            s1_nan        <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.y         <= '0;
            bus.ovf       <= 1'b0;
        end else begin
            if (s1_load) begin
                s1_valid <= bus.in_valid;
                if (bus.in_valid) begin
                    s1_sign <= bus.x[31];
                    s1_mag  <= dec_mag;
                    s1_rnd  <= dec_rnd;
                    s1_sat  <= dec_sat;
                    s1_min  <= dec_min;
                    s1_nan  <= dec_nan;
                end
            end
            if (s2_load) begin
                bus.out_valid <= s1_valid;
                if (s1_valid) begin
                    bus.y   <= y_next;
                    bus.ovf <= ovf_next;
                end
            end
        end
    end
endmodule

// File: tb/tb_ftoi_pipe.sv
// Scoreboard bench for ftoi_pipe: directed cases, back-pressure, reset, random traffic.
module tb_ftoi_pipe;
    typedef struct packed {
        logic        ovf;
        logic [31:0] y;
    } res_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ftoi_pipe_if bus();

    ftoi_pipe dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    res_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    logic rand_ready = 1'b0;
    logic ready_val  = 1'b1;
    logic saw_stall_in = 1'b0;

    task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: floor(2|v|) then halve with carry gives round-half-away
    function automatic res_t ref_conv(input logic [31:0] f);
        res_t        r;
        logic        s;
        int          e;
        logic [63:0] m;
        logic [63:0] mag;
        logic [63:0] twice;
        s = f[31];
        e = int'(f[30:23]);
        m = {40'b0, 1'b1, f[22:0]};
        if (e == 255) begin
            r.ovf = 1'b1;
            r.y   = (f[22:0] != 0 || !s) ? 32'h7FFF_FFFF : 32'h8000_0000;
            return r;
        end
        if (e == 0) begin
            mag = 64'd0;
        end else if (e >= 150) begin
            mag = (e >= 180) ? '1 : (m << (e - 150));
        end else begin
            twice = (m << 1) >> (150 - e);
            mag   = (twice + 64'd1) >> 1;
        end
        if (s) begin
            if (mag > 64'h8000_0000) begin
                r.ovf = 1'b1;
                r.y   = 32'h8000_0000;
            end else begin
                r.ovf = 1'b0;
                r.y   = 32'(64'd0 - mag);
            end
        end else begin
            if (mag >= 64'h8000_0000) begin
                r.ovf = 1'b1;
                r.y   = 32'h7FFF_FFFF;
            end else begin
                r.ovf = 1'b0;
                r.y   = mag[31:0];
            end
        end
        return r;
    endfunction

    // Consumer ready: fixed level or random, applied shortly after each edge
    always @(posedge clk) begin
        #2;
        bus.out_ready = rand_ready ? ($urandom_range(0, 99) < 75) : ready_val;
    end

    // Output monitor: every valid output must match the scoreboard head
    always @(negedge clk) begin
        if (!rst && bus.in_valid === 1'b1 && bus.in_ready === 1'b0) saw_stall_in = 1'b1;
        if (bus.out_valid === 1'b1) begin
            if (sb.size() == 0) begin
                n_checks++;
                assert (sb.size() != 0) else begin
                    n_fail++;
                    $error("FAIL spurious_out: observed y=%h ovf=%b expected no output", bus.y, bus.ovf);
                end
            end else begin
                check("result", {bus.ovf, bus.y}, sb[0]);
                if (bus.out_ready === 1'b1) void'(sb.pop_front());
            end
        end
    end

    task automatic send(input logic [31:0] v, input res_t exp);
        logic accepted;
        accepted = 1'b0;
        bus.in_valid = 1'b1;
        bus.x        = v;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (bus.in_ready === 1'b1) begin
                sb.push_back(exp);
                accepted = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (!accepted) check("accept_timeout", 33'd0, 33'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic send_m(input logic [31:0] v);
        send(v, ref_conv(v));
    endtask

    task automatic lat_check();
        int lat;
        lat = 1;
        @(negedge clk);
        while (bus.out_valid !== 1'b1 && lat < 8) begin
            lat++;
            @(negedge clk);
        end
        check("latency", 33'(lat), 33'd2);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        ready_val = 1'b1;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (sb.size() == 0) break;
        end
        check("drain_empty", 33'(sb.size()), 33'd0);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] gen_float();
        logic [31:0] v;
        logic [31:0] specials [8];
        specials = '{32'hCF00_0000, 32'h4F00_0000, 32'h7F80_0000, 32'hFF80_0000,
                     32'h7FC0_0000, 32'h8000_0000, 32'h3F00_0000, 32'hBF00_0000};
        case ($urandom_range(0, 3))
            0: v = $urandom;
            1: v = {1'($urandom_range(0, 1)), 8'($urandom_range(118, 160)), 23'($urandom)};
            2: v = {1'($urandom_range(0, 1)), 8'($urandom_range(150, 158)), 23'($urandom)};
            default: v = specials[$urandom_range(0, 7)];
        endcase
        return v;
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed timeout expected test completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.x        = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_out_valid", 33'(bus.out_valid), 33'd0);
        check("rst_y_ovf", {bus.ovf, bus.y}, 33'd0);
        check("rst_in_ready", 33'(bus.in_ready), 33'd1);
        @(posedge clk);
        #1;

        // Single operations with latency check
        send(32'h3F80_0000, res_t'({1'b0, 32'h0000_0001})); lat_check();
        send(32'h3FC0_0000, res_t'({1'b0, 32'h0000_0002})); lat_check();
        send(32'h4020_0000, res_t'({1'b0, 32'h0000_0003})); lat_check();
        send(32'hC020_0000, res_t'({1'b0, 32'hFFFF_FFFD})); lat_check();

        // Small and zero values
        send(32'h3EFA_E148, res_t'({1'b0, 32'h0000_0000}));
        send(32'h3F00_0000, res_t'({1'b0, 32'h0000_0001}));
        send(32'h8000_0000, res_t'({1'b0, 32'h0000_0000}));
        send(32'h0000_0001, res_t'({1'b0, 32'h0000_0000}));
        send(32'hBF00_0000, res_t'({1'b0, 32'hFFFF_FFFF}));
        drain();

        // Range edges
        send(32'h4EFF_FFFF, res_t'({1'b0, 32'h7FFF_FF80}));
        send(32'hCF00_0000, res_t'({1'b0, 32'h8000_0000}));
        send(32'h4F00_0000, res_t'({1'b1, 32'h7FFF_FFFF}));
        send(32'hFF80_0000, res_t'({1'b1, 32'h8000_0000}));
        send(32'h7FC0_0000, res_t'({1'b1, 32'h7FFF_FFFF}));
        send(32'hFFC0_0000, res_t'({1'b1, 32'h7FFF_FFFF}));
        drain();

        // Back-pressure: consumer stalls for 3 cycles mid-stream
        check("no_stall_before_bp", 33'(saw_stall_in), 33'd0);
        fork
            begin
                send(32'h3F80_0000, res_t'({1'b0, 32'd1}));
                send(32'h4000_0000, res_t'({1'b0, 32'd2}));
                send(32'h4040_0000, res_t'({1'b0, 32'd3}));
                send(32'h4080_0000, res_t'({1'b0, 32'd4}));
                send(32'h40A0_0000, res_t'({1'b0, 32'd5}));
            end
            begin
                repeat (2) @(posedge clk);
                #1;
                ready_val = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                ready_val = 1'b1;
            end
        join
        drain();
        check("in_ready_dropped", 33'(saw_stall_in), 33'd1);

        // Reset with two operands in flight
        ready_val = 1'b0;
        send(32'h4100_0000, res_t'({1'b0, 32'd8}));
        send(32'h4110_0000, res_t'({1'b0, 32'd9}));
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        @(negedge clk);
        check("rst2_out_valid", 33'(bus.out_valid), 33'd0);
        check("rst2_y_ovf", {bus.ovf, bus.y}, 33'd0);
        check("rst2_in_ready", 33'(bus.in_ready), 33'd1);
        @(posedge clk);
        #1;
        ready_val = 1'b1;
        send(32'h4120_0000, res_t'({1'b0, 32'd10}));
        lat_check();
        drain();

        // Random traffic with bubbles and random back-pressure
        rand_ready = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            send_m(gen_float());
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        @(posedge clk);
        #1;
        rand_ready = 1'b0;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/ftoi_pipe.md
Name: ftoi_pipe

Overview:
Pipelined IEEE-754 single-precision float to signed 32-bit integer converter, the inverse of the FPU's combinational int-to-float unit. Sits in the FPU execute path behind the float register read, feeding the integer writeback. Two register stages with valid/ready flow control, so the pipeline stalls cleanly on writeback back-pressure.

Parameters:
none (widths fixed: 32-bit float in, 32-bit two's-complement out)

Ports:
clk        input   1   clock; all state on rising edge
rst        input   1   synchronous reset, active-high
in_valid   input   1   x carries a valid operand this cycle
in_ready   output  1   converter accepts x this cycle
x          input   32  float operand {sign, exp[7:0], frac[22:0]}
out_valid  output  1   y/ovf valid
out_ready  input   1   consumer accepts y this cycle
y          output  32  signed integer result
ovf        output  1   result saturated (out of range, Inf or NaN)

Behaviour:
- Input transfer: in_valid & in_ready on a rising edge. Output transfer: out_valid & out_ready.
- Reset: s1_valid=0, s2_valid=0, out_valid=0, y=0, ovf=0. Reset mid-operation discards all in-flight operands; no output for them.
- Pipeline: S1 (decode/align) -> S2 (round/negate/saturate). Latency exactly 2 cycles from accept to out_valid with no stalls; throughput 1/cycle.
- Flow control: S2 loads when !s2_valid | out_ready. S1 loads when !s1_valid | S2 loads. in_ready = !s1_valid | (!s2_valid | out_ready); combinational path out_ready -> in_ready permitted. A stalled stage holds its data and valid unchanged. Output held stable while out_valid & !out_ready.
- S1, with e = exp, k = e - 127, M = {1'b1, frac} (24 bits):
  - e == 0 (zero/denormal): magnitude 0, round 0.
  - e == 255 (Inf/NaN): sat = 1.
  - k < -1: magnitude 0, round 0.
  - k == -1: magnitude 0, round 1.
  - 0 <= k <= 23: magnitude = M >> (23 - k); round = M[22 - k] (for k = 23, round = 0).
  - 24 <= k <= 30: magnitude = M << (k - 23), round = 0.
  - k >= 31: sat = 1, except x == 32'hCF000000 (exactly -2^31) -> special min flag.
  - Register sign, 31-bit magnitude, round bit, sat and min flags.
- S2: mag_r = magnitude + round (round half away from zero; never exceeds 31 bits). y = sign ? -mag_r : mag_r.
  - min flag: y = 32'h80000000, ovf = 0.
  - sat: y = sign ? 32'h80000000 : 32'h7FFFFFFF, ovf = 1. NaN forces y = 32'h7FFFFFFF regardless of sign.
  - -0.0 and negative values rounding to 0 give y = 0, not negative zero.
- y and ovf are registered in S2; no combinational path from x to y.

Test Plan:
- Single ops, out_ready=1: 0x3F800000 -> y=1; 0x3FC00000 -> y=2; 0x40200000 -> y=3; 0xC0200000 -> y=0xFFFFFFFD; each out_valid exactly 2 cycles after accept; ovf=0.
- Small/zero: 0x3EFAE148 (0.49) -> 0; 0x3F000000 (0.5) -> 1; 0x80000000 -> 0; 0x00000001 (denormal) -> 0.
- Range edges: 0x4EFFFFFF -> 0x7FFFFF80, ovf=0; 0xCF000000 -> 0x80000000, ovf=0; 0x4F000000 -> 0x7FFFFFFF, ovf=1; 0xFF800000 -> 0x80000000, ovf=1; 0x7FC00000 -> 0x7FFFFFFF, ovf=1.
- Back-pressure: stream 1.0..5.0 back-to-back with out_ready low for 3 cycles mid-stream -> in_ready drops once both stages are full, y holds, results 1..5 in order with no loss or duplication.
- Bubbles: random in_valid/out_ready over 10k random floats -> output sequence matches a reference model (round half away, saturation rules), order preserved.
- Reset: assert rst for 1 cycle with 2 ops in flight -> next cycle out_valid=0, y=0, ovf=0, in_ready=1; neither op is emitted; the next accepted op emerges after 2 cycles.
